// File: rtl/cbuf_stream_reader.sv
// Circular-buffer read adapter: prefetches through a 3-entry queue and frames a valid/ready
// stream into PKT_LEN-beat packets. Optional counters: define CBUF_RD_STATS_EN.
module cbuf_stream_reader #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int PKT_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              buf_empty,
    input  logic [ADDR_W:0]   buf_count,
    output logic              buf_read_en,
    input  logic [DATA_W-1:0] buf_data_out,
    input  logic              flush,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
`ifdef CBUF_RD_STATS_EN
    output logic [15:0]       beat_total,
    output logic [15:0]       pkt_total,
    output logic [15:0]       stall_cycles,
`endif
    output logic              busy
);

    localparam logic       ST_RUN   = 1'b0;
    localparam logic       ST_FLUSH = 1'b1;
    localparam logic [7:0] LAST_CNT = 8'(PKT_LEN - 1);

    logic [DATA_W-1:0] mem_q [0:2];
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q;
    logic              state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              in_run;
    logic              push;
    logic              hs;
    logic              buf_count_unused;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Occupancy is advisory only; read gating relies on buf_empty.
    assign buf_count_unused = ^buf_count;

    assign in_run  = (state_q == ST_RUN);
    assign m_valid = (occ_q != 2'd0) && in_run;
    assign hs      = m_valid && m_ready;
    assign m_last  = m_valid && (cnt_q == LAST_CNT);
    assign m_data  = m_valid ? mem_q[rd_ptr_q] : '0;
    assign busy    = (occ_q != 2'd0) || inflight_q || !in_run;
    assign push    = inflight_q && in_run && !flush;

    // Same-cycle pops are not credited, keeping the queue overflow-free.
    assign buf_read_en = !rst && in_run && !flush && !buf_empty &&
                         (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);

    always_comb begin
        state_d  = state_q;
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (in_run && flush) begin
            state_d  = ST_FLUSH;
            occ_d    = 2'd0;
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            cnt_d    = 8'd0;
        end else if (!in_run) begin
            if (!inflight_q) begin
                state_d = ST_RUN;
            end
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (hs) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                cnt_d    = m_last ? 8'd0 : cnt_q + 8'd1;
            end
            occ_d = occ_q + {1'b0, push} - {1'b0, hs};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            occ_q      <= 2'd0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            cnt_q      <= 8'd0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            inflight_q <= buf_read_en;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= buf_data_out;
        end
    end

`ifdef CBUF_RD_STATS_EN
    logic [15:0] beat_total_q, pkt_total_q, stall_cycles_q;

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_total_q   <= 16'd0;
            pkt_total_q    <= 16'd0;
            stall_cycles_q <= 16'd0;
        end else begin
            if (hs) begin
                beat_total_q <= sat_inc(beat_total_q);
            end
            if (hs && m_last) begin
                pkt_total_q <= sat_inc(pkt_total_q);
            end
            if (m_valid && !m_ready) begin
                stall_cycles_q <= sat_inc(stall_cycles_q);
            end
        end
    end

    assign beat_total   = beat_total_q;
    assign pkt_total    = pkt_total_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_cbuf_stream_reader.sv
// Directed bench for cbuf_stream_reader with a behavioural circular-buffer model upstream.
module tb_cbuf_stream_reader;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 3;
    localparam int PKT_LEN = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              buf_empty;
    logic [ADDR_W:0]   buf_count;
    logic              buf_read_en;
    logic [DATA_W-1:0] buf_data_out = '0;
    logic              flush;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
`ifdef CBUF_RD_STATS_EN
    logic [15:0]       beat_total, pkt_total, stall_cycles;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    // Upstream circular buffer: 8 words, registered read data one cycle after the pop.
    logic       bm_rst;
    logic       push_en;
    logic [7:0] push_data;
    logic [7:0] bmem [0:7];
    logic [2:0] bwr, brd;
    logic [3:0] bcnt;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bm_rst) begin
            bwr  <= 3'd0;
            brd  <= 3'd0;
            bcnt <= 4'd0;
        end else begin
            if (push_en) begin
                bmem[bwr] <= push_data;
                bwr       <= bwr + 3'd1;
            end
            if (buf_read_en) begin
                buf_data_out <= bmem[brd];
                brd          <= brd + 3'd1;
            end
            bcnt <= bcnt + 4'(push_en) - 4'(buf_read_en);
        end
    end

    assign buf_empty = (bcnt == 4'd0);
    assign buf_count = bcnt;

    cbuf_stream_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PKT_LEN(PKT_LEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .buf_empty    (buf_empty),
        .buf_count    (buf_count),
        .buf_read_en  (buf_read_en),
        .buf_data_out (buf_data_out),
        .flush        (flush),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
`ifdef CBUF_RD_STATS_EN
        .beat_total   (beat_total),
        .pkt_total    (pkt_total),
        .stall_cycles (stall_cycles),
`endif
        .busy         (busy)
    );

    task automatic preload(input int n, input logic [7:0] base);
        @(negedge clk);
        rst    = 1'b1;
        bm_rst = 1'b1;
        @(negedge clk);
        bm_rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            push_en   = 1'b1;
            push_data = base + 8'(i);
            @(negedge clk);
        end
        push_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        vec_cnt++; if (buf_read_en !== 1'b0) begin err_cnt++; $display("FAIL reset_rd_en got %b expected 0", buf_read_en); end
        vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got %b expected 0", m_valid); end
        vec_cnt++; if (m_last !== 1'b0) begin err_cnt++; $display("FAIL reset_last got %b expected 0", m_last); end
        vec_cnt++; if (m_data !== 8'h00) begin err_cnt++; $display("FAIL reset_data got %0h expected 0", m_data); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b expected 0", busy); end
`ifdef CBUF_RD_STATS_EN
        vec_cnt++; if (beat_total !== 16'd0) begin err_cnt++; $display("FAIL reset_beat_total got %0d expected 0", beat_total); end
        vec_cnt++; if (pkt_total !== 16'd0) begin err_cnt++; $display("FAIL reset_pkt_total got %0d expected 0", pkt_total); end
`endif
    endtask

    task automatic test_startup();
        int b = 0;
        int first_rd = -1;
        preload(8, 8'd1);
        m_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            if (buf_read_en && first_rd < 0) first_rd = c;
            if (m_valid && m_ready) begin
                vec_cnt++; if (m_data !== 8'(b + 1)) begin err_cnt++; $display("FAIL startup_data beat %0d got %0h expected %0h", b, m_data, b + 1); end
                vec_cnt++; if (m_last !== 1'(b % 4 == 3)) begin err_cnt++; $display("FAIL startup_last beat %0d got %b expected %b", b, m_last, (b % 4 == 3)); end
                vec_cnt++; if (c !== b + 2) begin err_cnt++; $display("FAIL startup_timing beat %0d at cycle %0d expected %0d", b, c, b + 2); end
                b++;
            end
        end
        vec_cnt++; if (first_rd !== 0) begin err_cnt++; $display("FAIL startup_first_rd got %0d expected 0", first_rd); end
        vec_cnt++; if (b !== 8) begin err_cnt++; $display("FAIL startup_beats got %0d expected 8", b); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL startup_idle_busy got %b expected 0", busy); end
`ifdef CBUF_RD_STATS_EN
        vec_cnt++; if (beat_total !== 16'd8) begin err_cnt++; $display("FAIL stats_beat_total got %0d expected 8", beat_total); end
        vec_cnt++; if (pkt_total !== 16'd2) begin err_cnt++; $display("FAIL stats_pkt_total got %0d expected 2", pkt_total); end
        vec_cnt++; if (stall_cycles !== 16'd0) begin err_cnt++; $display("FAIL stats_stall got %0d expected 0", stall_cycles); end
`endif
    endtask

    task automatic test_backpressure();
        int b = 0;
        int occ_m = 0;
        int inf_m = 0;
        logic hs;
        logic exp_rd;
        logic pv = 1'b0;
        logic [7:0] pd = 8'h00;
        preload(8, 8'd1);
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            rst     = 1'b0;
            m_ready = (c % 4 == 0) || (c % 4 == 3);
            #1;
            exp_rd = !buf_empty && (occ_m + inf_m < 3);
            vec_cnt++; if (buf_read_en !== exp_rd) begin err_cnt++; $display("FAIL bp_rd_gate cycle %0d got %b expected %b", c, buf_read_en, exp_rd); end
            if (pv) begin
                vec_cnt++; if (m_valid !== 1'b1 || m_data !== pd) begin err_cnt++; $display("FAIL bp_hold cycle %0d got v=%b d=%0h expected v=1 d=%0h", c, m_valid, m_data, pd); end
            end
            hs = m_valid && m_ready;
            if (hs) begin
                vec_cnt++; if (m_data !== 8'(b + 1)) begin err_cnt++; $display("FAIL bp_data beat %0d got %0h expected %0h", b, m_data, b + 1); end
                vec_cnt++; if (m_last !== 1'(b % 4 == 3)) begin err_cnt++; $display("FAIL bp_last beat %0d got %b expected %b", b, m_last, (b % 4 == 3)); end
                b++;
            end
            pv    = m_valid && !m_ready;
            pd    = m_data;
            occ_m = occ_m + inf_m - (hs ? 1 : 0);
            inf_m = buf_read_en ? 1 : 0;
        end
        m_ready = 1'b1;
        vec_cnt++; if (b !== 8) begin err_cnt++; $display("FAIL bp_beats got %0d expected 8", b); end
    endtask

    task automatic test_underflow();
        int b = 0;
        logic [7:0] exp_d [0:3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h12; exp_d[2] = 8'h13; exp_d[3] = 8'h14;
        preload(2, 8'h11);
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rst       = 1'b0;
            push_en   = (c == 7) || (c == 8);
            push_data = (c == 7) ? 8'h13 : 8'h14;
            #1;
            if (c == 5 || c == 6) begin
                vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL uf_gap_valid cycle %0d got %b expected 0", c, m_valid); end
            end
            if (m_valid && m_ready) begin
                if (b < 4) begin
                    vec_cnt++; if (m_data !== exp_d[b]) begin err_cnt++; $display("FAIL uf_data beat %0d got %0h expected %0h", b, m_data, exp_d[b]); end
                    vec_cnt++; if (m_last !== 1'(b == 3)) begin err_cnt++; $display("FAIL uf_last beat %0d got %b expected %b", b, m_last, (b == 3)); end
                end
                b++;
            end
        end
        push_en = 1'b0;
        vec_cnt++; if (b !== 4) begin err_cnt++; $display("FAIL uf_beats got %0d expected 4", b); end
    endtask

    task automatic test_flush();
        int b = 0;
        preload(8, 8'd1);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            rst     = 1'b0;
            flush   = (c == 3);
            m_ready = (c >= 4);
            #1;
            if (c == 3) begin
                vec_cnt++; if (m_valid !== 1'b1 || m_data !== 8'd1) begin err_cnt++; $display("FAIL fl_pre_head got v=%b d=%0h expected v=1 d=1", m_valid, m_data); end
                vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL fl_pre_busy got %b expected 1", busy); end
            end
            if (c == 4) begin
                vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL fl_valid_drop got %b expected 0", m_valid); end
                vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL fl_state_busy got %b expected 1", busy); end
                vec_cnt++; if (buf_read_en !== 1'b0) begin err_cnt++; $display("FAIL fl_no_read got %b expected 0", buf_read_en); end
            end
            if (c == 5) begin
                vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL fl_busy_clear got %b expected 0", busy); end
                vec_cnt++; if (buf_read_en !== 1'b1) begin err_cnt++; $display("FAIL fl_resume_read got %b expected 1", buf_read_en); end
            end
            if (m_valid && m_ready) begin
                vec_cnt++; if (m_data !== 8'(b + 4)) begin err_cnt++; $display("FAIL fl_data beat %0d got %0h expected %0h", b, m_data, b + 4); end
                vec_cnt++; if (m_last !== 1'(b % 4 == 3)) begin err_cnt++; $display("FAIL fl_last beat %0d got %b expected %b", b, m_last, (b % 4 == 3)); end
                b++;
            end
        end
        flush = 1'b0;
        vec_cnt++; if (b !== 5) begin err_cnt++; $display("FAIL fl_beats got %0d expected 5", b); end
    endtask

    task automatic test_wrap();
        int b = 0;
        preload(8, 8'd1);
        m_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            rst       = 1'b0;
            push_en   = (c == 3) || (c == 4);
            push_data = (c == 3) ? 8'd9 : 8'd10;
            #1;
            if (m_valid && m_ready) begin
                vec_cnt++; if (m_data !== 8'(b + 1)) begin err_cnt++; $display("FAIL wrap_data beat %0d got %0h expected %0h", b, m_data, b + 1); end
                vec_cnt++; if (m_last !== 1'(b % 4 == 3)) begin err_cnt++; $display("FAIL wrap_last beat %0d got %b expected %b", b, m_last, (b % 4 == 3)); end
                b++;
            end
        end
        push_en = 1'b0;
        vec_cnt++; if (b !== 10) begin err_cnt++; $display("FAIL wrap_beats got %0d expected 10", b); end
    endtask

    task automatic test_reset_mid();
        int b = 0;
        preload(8, 8'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rst     = 1'b0;
            m_ready = (c < 4);
            #1;
        end
        vec_cnt++; if (m_valid !== 1'b1 || m_data !== 8'd3 || m_last !== 1'b0) begin err_cnt++; $display("FAIL rm_pre got v=%b d=%0h l=%b expected v=1 d=3 l=0", m_valid, m_data, m_last); end
        #2;
        rst = 1'b1;
        #1;
        vec_cnt++; if (m_valid !== 1'b0) begin err_cnt++; $display("FAIL rm_async_valid got %b expected 0", m_valid); end
        vec_cnt++; if (m_data !== 8'h00) begin err_cnt++; $display("FAIL rm_async_data got %0h expected 0", m_data); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rm_async_busy got %b expected 0", busy); end
        vec_cnt++; if (buf_read_en !== 1'b0) begin err_cnt++; $display("FAIL rm_async_rd_en got %b expected 0", buf_read_en); end
`ifdef CBUF_RD_STATS_EN
        vec_cnt++; if (beat_total !== 16'd0) begin err_cnt++; $display("FAIL rm_stats_clear got %0d expected 0", beat_total); end
`endif
        preload(4, 8'h21);
        m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            if (m_valid && m_ready) begin
                vec_cnt++; if (m_data !== 8'h21 + 8'(b)) begin err_cnt++; $display("FAIL rm_data beat %0d got %0h expected %0h", b, m_data, 8'h21 + 8'(b)); end
                vec_cnt++; if (m_last !== 1'(b == 3)) begin err_cnt++; $display("FAIL rm_last beat %0d got %b expected %b", b, m_last, (b == 3)); end
                b++;
            end
        end
        vec_cnt++; if (b !== 4) begin err_cnt++; $display("FAIL rm_beats got %0d expected 4", b); end
    endtask

    initial begin
        rst       = 1'b1;
        bm_rst    = 1'b1;
        push_en   = 1'b0;
        push_data = 8'h00;
        flush     = 1'b0;
        m_ready   = 1'b0;
        test_reset();
        test_startup();
        test_backpressure();
        test_underflow();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/cbuf_stream_reader.md
Name: cbuf_stream_reader

Overview:
- Read-side adapter that sits directly downstream of the circular buffer.
- Pops words from the buffer's write_en/read_en pop interface and presents them on a valid/ready stream port.
- Frames the stream into fixed-length packets (m_last on the final beat).
- Prefetches through a 3-entry internal queue so a consumer that holds m_ready high sustains 1 beat/cycle despite the buffer's 1-cycle read latency.

Parameters:
- DATA_W, 8, word width; must match the buffer data width.
- ADDR_W, 3, buffer address width; buf_count is ADDR_W+1 bits.
- PKT_LEN, 4, beats per packet; legal range 1..255.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- buf_empty  in  1  buffer empty flag.
- buf_count  in  ADDR_W+1  buffer occupancy (status only; not used for read gating).
- buf_read_en  out  1  pop strobe to the buffer.
- buf_data_out  in  DATA_W  buffer read data; valid one cycle after buf_read_en.
- flush  in  1  single-cycle request to discard queued data and restart packet framing.
- m_data  out  DATA_W  stream data, taken from the queue head.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  final beat of the packet.
- busy  out  1  high when the queue is non-empty, a read is in flight, or the FSM is in FLUSH.

Behaviour:
- Reset, asynchronous:
  - queue empty, in-flight flag 0, beat counter 0, FSM in RUN.
  - buf_read_en=0, m_valid=0, m_last=0, m_data=0, busy=0.
  - buf_read_en is also forced 0 combinationally while rst=1.
- Buffer timing contract: buf_read_en sampled at edge N → word on buf_data_out in cycle N+1 → captured into the queue at edge N+1.
- Read issue, combinational:
  - buf_read_en = !rst && state==RUN && !flush && !buf_empty && (occ + inflight) < 3.
  - occ = queue occupancy (0..3); inflight = 1 if a read was issued last cycle.
  - A same-cycle downstream pop is not credited, so gating stays conservative.
- Queue:
  - 3-entry FIFO with registered pointers.
  - Capture on inflight, pop on m_valid && m_ready; both in the same cycle leave occ unchanged.
  - The occ+inflight<3 gate makes overflow impossible.
- Stream output:
  - m_valid = occ!=0 && state==RUN; m_data = head entry.
  - m_data and m_last stay stable while m_valid && !m_ready.
  - m_valid never deasserts without a handshake, except on flush or reset.
- Framing:
  - beat counter 0..PKT_LEN-1, increments on handshake, wraps to 0 after the beat where m_last=1.
  - m_last = m_valid && (cnt == PKT_LEN-1); with PKT_LEN=1, every beat has m_last=1.
- Throughput: with the buffer never empty and m_ready=1, the first m_valid is 2 cycles after the first buf_read_en, then 1 beat/cycle.
- FSM:
  - RUN → FLUSH when flush=1: queue cleared, counter reset to 0, m_valid=0 from the next cycle, no reads issued.
  - FLUSH: any in-flight word arriving is discarded.
  - FLUSH → RUN on the next cycle once inflight=0 (FLUSH lasts 1 cycle).
  - flush asserted while in FLUSH is absorbed.
- Buffer empty mid-packet: reads stall, m_valid drops after the queue drains, and the beat counter holds its position. There is no timeout.
- busy = occ!=0 || inflight || state==FLUSH.

Optional Feature:
- Macro CBUF_RD_STATS_EN.
- When defined, adds three outputs:
  - beat_total out 16: count of accepted beats, saturating at 16'hFFFF.
  - pkt_total out 16: count of handshakes with m_last=1, saturating.
  - Both clear on reset only, not on flush.
  - stall_cycles out 16: count of cycles with m_valid && !m_ready, saturating.
- When not defined, these ports and their logic are absent and the module behaves identically otherwise.

Test Plan:
- Startup: reset, then buffer preloaded with 1..8, m_ready=1 → buf_read_en in 3 consecutive cycles, then 1/cycle; m_data sequence 1,2,…,8 on consecutive cycles; m_last on beats 4 and 8.
- Backpressure: buffer holds 8 words, m_ready toggles 1,0,0,1 → no read issued while occ+inflight=3; data is held stable during stalls; no loss or duplication; output remains 1..8.
- Underflow mid-packet: only 2 words (0x11,0x12) are written, 5 cycles pass, then 0x13,0x14 → m_valid low in the gap; m_last only on 0x14; the counter resumes at 2.
- Flush with a read in flight: flush pulses the cycle after buf_read_en with occ=2 → m_valid=0 next cycle, the arriving word is discarded, busy=0 two cycles later, and the next packet starts at cnt=0 with the next buffer word.
- Wrap-around: the buffer write pointer wraps (push 8, pop 3, push 2) → the reader outputs the correct sequence 1..8,9,10 with packet boundaries every 4 beats.
- Reset mid-packet: rst asserted when cnt=2 and occ=2 → all outputs 0 asynchronously; after release, framing restarts at cnt=0. With CBUF_RD_STATS_EN defined, the counters read 0 after reset and beat_total=8, pkt_total=2 after the first test.
